instr_fetch_assembler: RTL and testbench

- Sequential front end between instruction memory and the execute stage.
- Accepts 16-bit instruction words over a valid/ready stream and classifies each first word into its instruction group.
- Joins group-5 two-word instructions (hi word plus 16-bit immediate lo word) into one entry.
- Buffers complete instructions in a DEPTH-entry FIFO; downstream pops through a second valid/ready handshake.

---
 rtl/instr_fetch_assembler_pkg.sv | 39 +++
 rtl/instr_fetch_assembler_fifo.sv | 49 ++++
 rtl/instr_fetch_assembler.sv | 85 ++++++++
 tb/tb_instr_fetch_assembler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_assembler_pkg.sv
// instr_fetch_assembler_pkg: instruction groups, fetch FSM states, entry layout and classifier
package instr_fetch_assembler_pkg;

    typedef enum logic [2:0] {
        instr_grp_unknown = 3'd0,
        instr_grp_1       = 3'd1,
        instr_grp_2       = 3'd2,
        instr_grp_3       = 3'd3,
        instr_grp_4       = 3'd4,
        instr_grp_5       = 3'd5
    } instr_group;

    typedef enum logic {S_HI, S_LO} ifa_fsm_state;

    // Address is appended outside the struct so its width can follow ADDR_WIDTH
    typedef struct packed {
        instr_group  group;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        len2;
    } ifa_body;

    localparam int IFA_BODY_W = $bits(ifa_body);

    localparam logic       GRP1_PAT = 1'b0;
    localparam logic [1:0] GRP2_PAT = 2'b10;
    localparam logic [3:0] GRP3_PAT = 4'b1100;
    localparam logic [3:0] GRP4_PAT = 4'b1101;
    localparam logic [5:0] GRP5_PAT = 6'b111000;

    function automatic instr_group classify(input logic [15:0] w);
        return w[15] == GRP1_PAT       ? instr_grp_1 :
               w[15:14] == GRP2_PAT    ? instr_grp_2 :
               w[15:12] == GRP3_PAT    ? instr_grp_3 :
               w[15:12] == GRP4_PAT    ? instr_grp_4 :
               w[15:10] == GRP5_PAT    ? instr_grp_5 : instr_grp_unknown;
    endfunction

endpackage

// File: rtl/instr_fetch_assembler_fifo.sv
// ifa_fifo: DEPTH-entry circular buffer with push/pop/flush and occupancy count
module ifa_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && count != '0;
    assign dout   = mem[rd_ptr];

    // Pointers are exactly AW bits, so wrap modulo DEPTH comes for free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_assembler.sv
// instr_fetch_assembler: classifies fetched words, joins group-5 pairs and queues whole instructions
module instr_fetch_assembler
    import instr_fetch_assembler_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             in_word,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output instr_group              out_group,
    output logic [15:0]             out_instr_hi,
    output logic [15:0]             out_instr_lo,
    output logic                    out_len2,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int EW = IFA_BODY_W + ADDR_WIDTH;

    ifa_fsm_state          state;
    logic [15:0]           hi_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    instr_group            grp;
    logic                  accept;
    logic                  push;
    logic [EW-1:0]         din;
    logic [EW-1:0]         dout;
    ifa_body               head;

    assign grp      = classify(in_word);
    assign in_ready = count < ($clog2(DEPTH)+1)'(DEPTH) && !reset;
    assign accept   = in_valid && in_ready && !flush;
    assign push     = accept && (state == S_LO || grp != instr_grp_5);
    // In S_LO the incoming word is the immediate and is never classified
    assign din      = state == S_LO ? {instr_grp_5, hi_q, in_word, 1'b1, addr_q}
                                    : {grp, in_word, 16'h0000, 1'b0, in_addr};

    assign {head, out_addr} = dout;
    assign out_group    = head.group;
    assign out_instr_hi = head.hi;
    assign out_instr_lo = head.lo;
    assign out_len2     = head.len2;
    assign out_valid    = count != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_HI;
            hi_q   <= '0;
            addr_q <= '0;
        end else if (flush) begin
            state  <= S_HI;
            hi_q   <= '0;
            addr_q <= '0;
        end else if (accept) begin
            if (state == S_HI && grp == instr_grp_5) begin
                state  <= S_LO;
                hi_q   <= in_word;
                addr_q <= in_addr;
            end else begin
                state <= S_HI;
            end
        end
    end

    ifa_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (out_ready),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    assert property (@(posedge clk) disable iff (reset)
        in_valid && !in_ready && !flush |=> in_valid && $stable(in_word) && $stable(in_addr));

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// tb_instr_fetch_assembler: directed and randomized checks against a queue-based reference model
module tb_instr_fetch_assembler;
    import instr_fetch_assembler_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        reset = 1;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] in_word = 0;
    logic [15:0] in_addr = 0;
    logic        out_valid;
    logic        out_ready = 0;
    instr_group  out_group;
    logic [15:0] out_instr_hi;
    logic [15:0] out_instr_lo;
    logic        out_len2;
    logic [15:0] out_addr;
    logic [2:0]  count;

    instr_fetch_assembler #(.DEPTH(DEPTH), .ADDR_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_group(out_group),
        .out_instr_hi(out_instr_hi), .out_instr_lo(out_instr_lo), .out_len2(out_len2),
        .out_addr(out_addr), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        instr_group  g;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        len2;
        logic [15:0] addr;
    } ent_t;

    ent_t        q[$];
    logic        pend = 0;
    logic [15:0] phi = 0;
    logic [15:0] paddr = 0;
    logic        hold = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Numeric ranges of the first word map directly to groups
    function automatic instr_group ref_grp(input logic [15:0] w);
        if (w < 16'h8000) return instr_grp_1;
        if (w < 16'hC000) return instr_grp_2;
        if (w < 16'hD000) return instr_grp_3;
        if (w < 16'hE000) return instr_grp_4;
        if (w < 16'hE400) return instr_grp_5;
        return instr_grp_unknown;
    endfunction

    task automatic compare();
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        if (q.size() != 0) begin
            chk("group", 32'(out_group), 32'(q[0].g));
            chk("hi", 32'(out_instr_hi), 32'(q[0].hi));
            chk("lo", 32'(out_instr_lo), 32'(q[0].lo));
            chk("len2", 32'(out_len2), 32'(q[0].len2));
            chk("addr", 32'(out_addr), 32'(q[0].addr));
        end
    endtask

    // Called at a falling edge: drive, update the model, clock, then compare
    task automatic tick(input logic v, input logic [15:0] w, input logic [15:0] a,
                        input logic r, input logic f);
        logic rdy, acc, pop;
        ent_t e;
        in_valid = v; in_word = w; in_addr = a; out_ready = r; flush = f;
        rdy  = q.size() < DEPTH;
        acc  = v && rdy && !f;
        pop  = q.size() != 0 && r && !f;
        hold = v && !rdy && !f;
        if (f) begin
            q.delete();
            pend = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (pend) begin
                    e = '{instr_grp_5, phi, w, 1'b1, paddr};
                    q.push_back(e);
                    pend = 0;
                end else if (ref_grp(w) == instr_grp_5) begin
                    pend = 1; phi = w; paddr = a;
                end else begin
                    e = '{ref_grp(w), w, 16'h0000, 1'b0, a};
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 5))
            0: return {1'b0, r[14:0]};
            1: return {2'b10, r[13:0]};
            2: return {4'hC, r[11:0]};
            3: return {4'hD, r[11:0]};
            4: return {6'b111000, r[9:0]};
            default: return 16'hE400 + 16'($urandom_range(0, 16'h1BFF));
        endcase
    endfunction

    initial begin
        logic        cv, cf, cr;
        logic [15:0] cw, ca, pc;
        int          rate;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_hi", 32'(out_instr_hi), 0);
        chk("rst_addr", 32'(out_addr), 0);
        @(negedge clk);
        reset = 0;

        tick(1, 16'h1234, 16'h0100, 1, 0);
        chk("g1_group", 32'(out_group), 32'(instr_grp_1));
        chk("g1_hi", 32'(out_instr_hi), 32'h1234);
        tick(0, 0, 0, 1, 0);
        chk("g1_gone", 32'(out_valid), 0);

        tick(1, 16'hE0A5, 16'h0200, 1, 0);
        chk("g5_wait", 32'(out_valid), 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        chk("g5_hold", 32'(out_valid), 0);
        tick(1, 16'hBEEF, 16'h0201, 1, 0);
        chk("g5_group", 32'(out_group), 32'(instr_grp_5));
        chk("g5_lo", 32'(out_instr_lo), 32'hBEEF);
        chk("g5_addr", 32'(out_addr), 32'h0200);
        tick(0, 0, 0, 1, 0);

        for (int i = 1; i <= 4; i++) tick(1, 16'hD000 + 16'(i), 16'h0300 + 16'(i), 0, 0);
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(in_ready), 0);
        tick(1, 16'hD005, 16'h0305, 1, 0);
        chk("full_pop_head", 32'(out_instr_hi), 32'hD002);
        chk("full_ready_back", 32'(in_ready), 1);
        tick(1, 16'hD005, 16'h0305, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("full_order", 32'(out_instr_hi), 32'hD002 + k);
            tick(0, 0, 0, 1, 0);
        end

        tick(1, 16'h0010, 16'h0400, 0, 0);
        tick(1, 16'h0011, 16'h0401, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(1, 16'h0020 + 16'(i), 16'h0410 + 16'(i), 1, 0);
            chk("steady_count", 32'(count), 2);
        end
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);

        tick(1, 16'hE000, 16'h0500, 1, 0);
        tick(0, 0, 0, 1, 1);
        chk("flush_count", 32'(count), 0);
        tick(1, 16'h0042, 16'h0510, 1, 0);
        chk("flush_group", 32'(out_group), 32'(instr_grp_1));
        chk("flush_len2", 32'(out_len2), 0);
        tick(0, 0, 0, 1, 0);

        tick(1, 16'hF000, 16'h0600, 1, 0);
        chk("unk_group", 32'(out_group), 32'(instr_grp_unknown));
        chk("unk_len2", 32'(out_len2), 0);
        tick(0, 0, 0, 1, 0);

        pc = 16'h1000; cv = 0; cw = 0; ca = 0; rate = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) rate = $urandom_range(0, 2) == 0 ? 15 : ($urandom_range(0, 1) ? 50 : 90);
            if (!hold) begin
                cv = $urandom_range(0, 9) < 7;
                cw = pend ? 16'($urandom) : rand_word();
                ca = pc;
                pc = pc + 1;
            end
            cf = $urandom_range(0, 39) == 0;
            cr = $urandom_range(0, 99) < rate;
            tick(cv, cw, ca, cr, cf);
        end
        tick(cv, cw, ca, 0, 1);

        tick(1, 16'h0001, 16'h0700, 0, 0);
        tick(1, 16'h0002, 16'h0701, 0, 0);
        tick(1, 16'h0003, 16'h0702, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("pre_rst_count", 32'(count), 3);
        #2 reset = 1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_count", 32'(count), 0);
        q.delete();
        pend = 0;
        @(negedge clk);
        reset = 0;
        tick(1, 16'hC123, 16'h0800, 0, 0);
        tick(0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
